// File: rtl/reg_file_pkg.sv
// Shared CPU constants for the integer register file and its write scoreboard.
package reg_file_pkg;

  localparam int CPU_XLEN   = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // One-hot select of a register number; used to build per-register strobes.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t num);
    reg_onehot = '0;
    reg_onehot[num] = 1'b1;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one saturating-guarded counter per register,
// operand busy detection, issue back-pressure and a sticky underflow flag.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] rs1_num_i,
  input  logic [REG_ADDR_W-1:0] rs2_num_i,
  input  logic                  issue_en_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic                  wb_en_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  pend_overflow_o
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [PEND_W-1:0] cnt_q [NUM_REGS];
  logic [PEND_W-1:0] cnt_d [NUM_REGS];
  logic              ovf_q;
  logic              ovf_d;

  logic                wb_live;
  logic                rs1_busy;
  logic                rs2_busy;
  logic                issue_full;
  logic                issue_ok;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  // x0 is never tracked, so a write-back to it neither retires nor underflows.
  assign wb_live = wb_en_i && (wb_rd_i != '0);

  // An operand is busy while writes are outstanding, unless the last one lands
  // this very cycle and the bypass path supplies it.
  assign rs1_busy = (cnt_q[rs1_num_i] != '0) &&
                    !((cnt_q[rs1_num_i] == CNT_ONE) && wb_live && (wb_rd_i == rs1_num_i));
  assign rs2_busy = (cnt_q[rs2_num_i] != '0) &&
                    !((cnt_q[rs2_num_i] == CNT_ONE) && wb_live && (wb_rd_i == rs2_num_i));

  // Issuing to a full counter would wrap it, unless a write-back frees a slot now.
  assign issue_full = issue_en_i && (cnt_q[issue_rd_i] == CNT_MAX) &&
                      !(wb_en_i && (wb_rd_i == issue_rd_i));

  assign stall_o         = rs1_busy || rs2_busy || issue_full;
  assign pend_overflow_o = ovf_q;

  assign issue_ok = issue_en_i && !stall_o && (issue_rd_i != '0);
  assign inc_vec  = issue_ok ? reg_onehot(issue_rd_i) : '0;
  assign dec_vec  = wb_live  ? reg_onehot(wb_rd_i)    : '0;

  // Next counter values: flush wins, an issue and a write-back to the same
  // register cancel, and a write-back to an idle counter leaves it at zero.
  always_comb begin
    // NOTE: every combinational output gets its hold value first so that no
    // path through the block leaves it unassigned and a latch is inferred.
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (wb_live && (cnt_q[wb_rd_i] == '0)) begin
      ovf_d = 1'b1;
    end
    if (flush_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_d[r] = '0;
      end
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
          cnt_d[r] = cnt_q[r] - CNT_ONE;
        end
      end
    end
  end

  // Counter and flag state; reset discards everything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Integer register file: 32 x XLEN storage with x0 hard-wired to zero,
// combinational reads with write-back bypass, and a pending-write scoreboard.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int XLEN   = CPU_XLEN,
  parameter int PEND_W = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] rs1_num,
  input  logic [REG_ADDR_W-1:0] rs2_num,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  output logic                  stall,
  output logic                  pend_overflow
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic            wr_en;

  assign wr_en = wb_en && (wb_rd != '0);

  // Architectural register storage; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the array is reset on purpose -- registers must read zero after
    // reset -- which rules out mapping it onto a RAM macro.
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // Read ports: x0 reads zero, otherwise forward a same-cycle write-back.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_num != '0) begin
      rs1_data = (wb_en && (wb_rd == rs1_num)) ? wb_data : regs_q[rs1_num];
    end
    if (rs2_num != '0) begin
      rs2_data = (wb_en && (wb_rd == rs2_num)) ? wb_data : regs_q[rs2_num];
    end
  end

  reg_scoreboard #(
    .PEND_W(PEND_W)
  ) u_scoreboard (
    .clk            (clk),
    .reset_n        (reset_n),
    .rs1_num_i      (rs1_num),
    .rs2_num_i      (rs2_num),
    .issue_en_i     (issue_en),
    .issue_rd_i     (issue_rd),
    .wb_en_i        (wb_en),
    .wb_rd_i        (wb_rd),
    .flush_i        (flush),
    .stall_o        (stall),
    .pend_overflow_o(pend_overflow)
  );

endmodule
